// File: rtl/pipelined_float_to_int_pkg.sv
// Shared definitions for the float-to-int return path: rounding-mode encoding (common with the
// float adder), single-precision field widths, integer saturation limits and operand classes.
package pipelined_float_to_int_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned EXP_BIAS = 127;

  localparam logic [1:0] RM_NEAREST = 2'b00;
  localparam logic [1:0] RM_DOWN    = 2'b01;
  localparam logic [1:0] RM_UP      = 2'b10;
  localparam logic [1:0] RM_ZERO    = 2'b11;

  localparam logic [31:0] INT_MAX = 32'h7fffffff;
  localparam logic [31:0] INT_MIN = 32'h80000000;

  typedef enum logic [2:0] {
    ClsZero,
    ClsDenorm,
    ClsNormal,
    ClsInf,
    ClsNan
  } op_class_e;

  function automatic op_class_e classify(logic [EXP_W-1:0] expo, logic [FRAC_W-1:0] frac);
    if (expo == '0) begin
      return (frac == '0) ? ClsZero : ClsDenorm;
    end
    if (expo == '1) begin
      return (frac == '0) ? ClsInf : ClsNan;
    end
    return ClsNormal;
  endfunction

endpackage

// File: rtl/pipelined_float_to_int_fp_round_incr.sv
// Rounding increment decision, shared with the float adder's rounding stage.
// Ports: sign (result sign), lsb (kept LSB), g (guard bit), s (sticky bit), rm (rounding mode),
//        incr (1 = add one ulp to the truncated magnitude).
module fp_round_incr
  import pipelined_float_to_int_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       s,
  input  logic [1:0] rm,
  output logic       incr
);

  always_comb begin
    incr = 1'b0;
    unique case (rm)
      RM_NEAREST: incr = g & (s | lsb);
      RM_DOWN:    incr = sign & (g | s);
      RM_UP:      incr = ~sign & (g | s);
      RM_ZERO:    incr = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipelined_float_to_int.sv
// Three-stage IEEE-754 single to signed 32-bit integer converter.
// Stages: 1 capture fields, 2 classify and align to an integer magnitude with guard/sticky,
//         3 round, saturate, negate and register the result with its flags.
// Ports: clk, clrn (async active-low reset), a (float operand), rm (rounding mode),
//        e (1 advances all stages, 0 holds them), in_valid, d (integer result), out_valid,
//        invalid (NaN/inf/out of range), inexact (rounded result differs from exact value).
module pipelined_float_to_int
  import pipelined_float_to_int_pkg::*;
#(
  parameter logic [31:0] NAN_RESULT = 32'h80000000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] a,
  input  logic [1:0]  rm,
  input  logic        e,
  input  logic        in_valid,
  output logic [31:0] d,
  output logic        out_valid,
  output logic        invalid,
  output logic        inexact
);

  // Biased exponents bounding the alignment cases.
  localparam logic [7:0] EXP_HALF    = 8'(EXP_BIAS - 1);        // value in [0.5, 1)
  localparam logic [7:0] EXP_NO_FRAC = 8'(EXP_BIAS + FRAC_W);   // lowest exp with no fraction
  localparam logic [7:0] EXP_MAX_INT = 8'(EXP_BIAS + 30);       // largest exp that always fits
  localparam logic [7:0] EXP_MIN_INT = 8'(EXP_BIAS + 31);       // only -2^31 fits here

  // Stage 1: captured fields.
  logic              s1_valid, s1_sign;
  logic [EXP_W-1:0]  s1_exp;
  logic [FRAC_W-1:0] s1_frac;
  logic [1:0]        s1_rm;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_rm    <= RM_NEAREST;
    end else if (e) begin
      s1_valid <= in_valid;
      s1_sign  <= a[31];
      s1_exp   <= a[30:23];
      s1_frac  <= a[22:0];
      s1_rm    <= rm;
    end
  end

  // Stage 2: classify and align.
  op_class_e   cls;
  logic [23:0] mant;
  logic [55:0] shr;
  logic [4:0]  rsh;
  logic [2:0]  lsh;
  logic [31:0] a2_mag;
  logic        a2_g, a2_s, a2_nan, a2_ovf;

  assign cls  = classify(s1_exp, s1_frac);
  assign mant = {cls == ClsNormal, s1_frac};

  always_comb begin
    a2_mag = '0;
    a2_g   = 1'b0;
    a2_s   = 1'b0;
    a2_nan = 1'b0;
    a2_ovf = 1'b0;
    rsh    = '0;
    lsh    = '0;
    shr    = '0;
    case (cls)
      ClsNan:    a2_nan = 1'b1;
      ClsInf:    a2_ovf = 1'b1;
      ClsZero:   ;
      ClsDenorm: a2_s = 1'b1;
      default: begin
        if (s1_exp < EXP_HALF) begin
          a2_s = 1'b1;
        end else if (s1_exp == EXP_HALF) begin
          a2_g = 1'b1;
          a2_s = |s1_frac;
        end else if (s1_exp <= EXP_NO_FRAC) begin
          // Park the discarded bits below bit 32 so guard and sticky fall out directly.
          rsh    = 5'(EXP_NO_FRAC - s1_exp);
          shr    = {mant, 32'b0} >> rsh;
          a2_mag = {8'b0, shr[55:32]};
          a2_g   = shr[31];
          a2_s   = |shr[30:0];
        end else if (s1_exp <= EXP_MAX_INT) begin
          lsh    = 3'(s1_exp - EXP_NO_FRAC);
          a2_mag = {8'b0, mant} << lsh;
        end else if (s1_sign && s1_exp == EXP_MIN_INT && s1_frac == '0) begin
          a2_mag = INT_MIN;
        end else begin
          a2_ovf = 1'b1;
        end
      end
    endcase
  end

  logic        s2_valid, s2_sign, s2_g, s2_s, s2_nan, s2_ovf;
  logic [1:0]  s2_rm;
  logic [31:0] s2_mag;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_rm    <= RM_NEAREST;
      s2_mag   <= '0;
      s2_g     <= 1'b0;
      s2_s     <= 1'b0;
      s2_nan   <= 1'b0;
      s2_ovf   <= 1'b0;
    end else if (e) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_rm    <= s1_rm;
      s2_mag   <= a2_mag;
      s2_g     <= a2_g;
      s2_s     <= a2_s;
      s2_nan   <= a2_nan;
      s2_ovf   <= a2_ovf;
    end
  end

  // Stage 3: round, saturate, negate.
  logic        incr;
  logic [31:0] sum;
  logic [31:0] r_d;
  logic        r_inv, r_inex;

  fp_round_incr u_round_incr (
    .sign (s2_sign),
    .lsb  (s2_mag[0]),
    .g    (s2_g),
    .s    (s2_s),
    .rm   (s2_rm),
    .incr (incr)
  );

  // Magnitude never exceeds 2^31 here, so bit 31 of the sum flags exactly 2^31.
  assign sum = s2_mag + {31'b0, incr};

  always_comb begin
    r_d    = '0;
    r_inv  = 1'b0;
    r_inex = 1'b0;
    if (s2_nan) begin
      r_d   = NAN_RESULT;
      r_inv = 1'b1;
    end else if (s2_ovf || (sum[31] && !s2_sign)) begin
      r_d   = s2_sign ? INT_MIN : INT_MAX;
      r_inv = 1'b1;
    end else begin
      r_d    = s2_sign ? (~sum + 32'd1) : sum;
      r_inex = s2_g | s2_s;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      d         <= '0;
      out_valid <= 1'b0;
      invalid   <= 1'b0;
      inexact   <= 1'b0;
    end else if (e) begin
      d         <= r_d;
      out_valid <= s2_valid;
      invalid   <= r_inv;
      inexact   <= r_inex;
    end
  end

endmodule

// File: doc/pipelined_float_to_int.md
Name: pipelined_float_to_int

Overview:
Three-stage pipelined converter from IEEE-754 single precision to signed 32-bit two's-complement integer. It is the return path for the pipelined float adder datapath: adder results are converted back into the integer domain. Rounding-mode encoding and the pipeline-enable convention match the adder. Invalid and inexact flags travel alongside each result.

Parameters:
NAN_RESULT, 32'h80000000, integer result driven for NaN inputs.

Ports:
clk  input  1  rising-edge clock.
clrn  input  1  asynchronous active-low reset.
a  input  32  float operand.
rm  input  2  rounding mode: 00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero.
e  input  1  pipeline enable: 1 advances all stages, 0 holds all stages.
in_valid  input  1  marks a as a real operand.
d  output  32  signed integer result.
out_valid  output  1  d, invalid and inexact are meaningful.
invalid  output  1  NaN, infinity or out-of-range input.
inexact  output  1  result differs from the exact value.

Behaviour:
- Reset: clk and clrn only; clrn low asynchronously clears every pipeline register. d=0, out_valid=0, invalid=0, inexact=0 while clrn is low and until the first new result.
- Stage 1 (capture/unpack): register sign, biased exp, frac, rm, in_valid. Classify as NaN, inf, zero, denormal or normal.
- Stage 2 (align): let E = exp-127 and M = {1,frac} (hidden bit 0 for denormals).
  - 0<=E<=30: magnitude = M scaled by 2^(E-23); g = first discarded bit; s = OR of the remaining discarded bits.
  - E=-1: magnitude=0, g=1, s=|frac.
  - E<=-2, or denormal nonzero: magnitude=0, g=0, s=1.
  - E>=31: overflow, except sign=1, exp=158, frac=0, which is exactly -2^31.
- Stage 3 (round/negate/saturate): rounding increment by mode.
  - rm 00: g&(s|lsb).
  - rm 01: sign&(g|s).
  - rm 10: ~sign&(g|s).
  - rm 11: 0.
  - Magnitude plus increment is 32 bits unsigned. If it equals 2^31 with sign=0, treat as overflow; with sign=1 the result is 0x80000000 with invalid=0.
  - Negate when sign=1.
- Special results:
  - NaN -> NAN_RESULT, invalid=1.
  - +inf or positive overflow -> 0x7fffffff, invalid=1.
  - -inf or negative overflow -> 0x80000000, invalid=1.
  - +/-0 -> 0, with both flags 0.
  - When invalid=1, inexact=0. Otherwise inexact = g|s.
- Latency: exactly 3 enabled clock edges from input to d. Throughput is one conversion per enabled edge.
- e=0 freezes every stage, including out_valid and the flags. No operand is lost or duplicated across any stall length.
- in_valid=0 bubbles propagate with out_valid=0. In a bubble, d and the flags hold the bubble's computed value; benches check only when out_valid=1.
- rm is sampled with a in stage 1 and travels with its operand. Changing rm mid-pipeline never affects operands already in flight.
- clrn asserted mid-operation discards all in-flight operands. The first post-reset result appears 3 enabled edges after in_valid is presented.
- Simultaneous e=0 and clrn=0: reset wins.

Decomposition:
- Shared package:
  - rounding-mode constants RM_NEAREST, RM_DOWN, RM_UP, RM_ZERO;
  - float field widths and EXP_BIAS=127;
  - INT_MAX=32'h7fffffff and INT_MIN=32'h80000000;
  - operand class encoding (ZERO, DENORM, NORMAL, INF, NAN).
- One sub-module, fp_round_incr: combinational, taking sign, lsb, g, s and rm and producing the increment bit. It is shareable with the float adder's rounding stage.

Test Plan:
- 1.5 (0x3fc00000) with rm=0,1,2,3 -> d=2,1,2,1; inexact=1 and invalid=0 for all four.
- -2.5 (0xc0200000) with rm=0,1,2,3 -> d=0xfffffffe, 0xfffffffd, 0xfffffffe, 0xfffffffe; inexact=1.
- Specials:
  - 0x7f800000 -> 0x7fffffff, invalid=1.
  - 0x7fc00000 -> 0x80000000, invalid=1.
  - 0x4f000000 -> 0x7fffffff, invalid=1.
  - 0xcf000000 -> 0x80000000, invalid=0, inexact=0.
  - 0x4effffff -> 0x7fffff80, exact.
- Small values:
  - 0x00000001 with rm=2 -> 1, inexact=1.
  - 0x00000001 with rm=0 -> 0, inexact=1.
  - 0x80000001 with rm=1 -> 0xffffffff.
  - 0x80000000 -> 0, no flags.
- Pipelining: back-to-back 0x3f800000, 0x40000000, 0x40400000 with e=1 -> d=1, 2, 3 with out_valid=1 on edges 3, 4, 5. Repeat with e=0 for 2 cycles after the second input -> outputs frozen during the stall, then 2 and 3 follow with no loss or duplication.
- Reset: drop clrn for 3 ns while two operands are in flight -> d=0 and out_valid=0 immediately, with no stale result after release. A new operand 0x41200000 produces d=10 three enabled edges later.
